// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan code decoder: bytes -> {break, extended, code} events in a show-ahead FIFO.
// Optional prefix timeout enabled by defining PS2_SCAN_TIMEOUT_EN.
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic [7:0]                    received_data,
  input  logic                          received_data_en,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [7:0]                    ev_code,
  output logic                          ev_extended,
  output logic                          ev_break,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overflow,
  input  logic                          clr_overflow,
  output logic                          ctrl_valid,
  output logic [7:0]                    ctrl_byte,
  output logic                          seq_error
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_E0   = 2'd1,
    GOT_F0   = 2'd2,
    GOT_E0F0 = 2'd3
  } state_t;

  state_t      state_r;
  state_t      nstate_s;
  logic        push_s;
  logic [9:0]  push_data_s;
  logic        ctrl_hit_s;
  logic        seq_err_s;
  logic        ctrl_valid_r;
  logic [7:0]  ctrl_byte_r;
  logic        seq_error_r;

  logic [9:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          overflow_r;
  logic          empty_s;
  logic          full_s;
  logic          pop_s;
  logic          wr_en_s;
  logic          drop_s;

  function automatic logic is_ctrl(input logic [7:0] b);
    case (b)
      8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'hFD, 8'h00, 8'hFF: is_ctrl = 1'b1;
      default:                                                 is_ctrl = 1'b0;
    endcase
  endfunction

`ifdef PS2_SCAN_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] tmo_cnt_r;

  // Idle-cycle counter, restarted by every byte and held at zero in IDLE
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tmo_cnt_r <= 32'd0;
    end else if (received_data_en || (state_r == IDLE)) begin
      tmo_cnt_r <= 32'd0;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + 32'd1;
    end
  end
`endif

  // Byte decode: next state, event push and control/error detection
  always_comb begin
    nstate_s    = state_r;
    push_s      = 1'b0;
    push_data_s = 10'd0;
    ctrl_hit_s  = 1'b0;
    seq_err_s   = 1'b0;
    if (received_data_en) begin
      case (state_r)
        IDLE: begin
          if (received_data == 8'hE0) begin
            nstate_s = GOT_E0;
          end else if (received_data == 8'hF0) begin
            nstate_s = GOT_F0;
          end else if (is_ctrl(received_data)) begin
            ctrl_hit_s = 1'b1;
          end else begin
            push_s      = 1'b1;
            push_data_s = {1'b0, 1'b0, received_data};
          end
        end
        GOT_E0: begin
          if (received_data == 8'hF0) begin
            nstate_s = GOT_E0F0;
          end else if (received_data == 8'hE0) begin
            nstate_s = GOT_E0;
          end else begin
            push_s      = 1'b1;
            push_data_s = {1'b0, 1'b1, received_data};
            nstate_s    = IDLE;
          end
        end
        GOT_F0, GOT_E0F0: begin
          nstate_s = IDLE;
          if ((received_data == 8'hE0) || (received_data == 8'hF0)) begin
            seq_err_s = 1'b1;
          end else begin
            push_s      = 1'b1;
            push_data_s = {1'b1, (state_r == GOT_E0F0), received_data};
          end
        end
        default: begin
          nstate_s = IDLE;
        end
      endcase
    end else begin
`ifdef PS2_SCAN_TIMEOUT_EN
      if ((state_r != IDLE) && (tmo_cnt_r == TMO_LAST)) begin
        nstate_s  = IDLE;
        seq_err_s = 1'b1;
      end else begin
        nstate_s = state_r;
      end
`else
      nstate_s = state_r;
`endif
    end
  end

  // Prefix FSM with registered control/error pulses
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r      <= IDLE;
      ctrl_valid_r <= 1'b0;
      ctrl_byte_r  <= 8'h00;
      seq_error_r  <= 1'b0;
    end else begin
      state_r      <= nstate_s;
      ctrl_valid_r <= ctrl_hit_s;
      seq_error_r  <= seq_err_s;
      if (ctrl_hit_s) begin
        ctrl_byte_r <= received_data;
      end
    end
  end

  assign empty_s = (count_r == CW'(0));
  assign full_s  = (count_r == CW'(FIFO_DEPTH));
  assign pop_s   = ev_ready && !empty_s;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign wr_en_s = push_s && (!full_s || pop_s);
  assign drop_s  = push_s && full_s && !pop_s;

  // Event storage; contents need no reset since outputs are gated by empty
  always_ff @(posedge CLOCK_50) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= push_data_s;
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      if (wr_en_s && !pop_s) begin
        count_r <= count_r + CW'(1);
      end else if (pop_s && !wr_en_s) begin
        count_r <= count_r - CW'(1);
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clr_overflow) begin
        overflow_r <= 1'b0;
      end
    end
  end

  assign ev_valid    = !empty_s;
  assign ev_code     = empty_s ? 8'h00 : mem_r[rd_ptr_r][7:0];
  assign ev_extended = empty_s ? 1'b0  : mem_r[rd_ptr_r][8];
  assign ev_break    = empty_s ? 1'b0  : mem_r[rd_ptr_r][9];
  assign fill_level  = count_r;
  assign overflow    = overflow_r;
  assign ctrl_valid  = ctrl_valid_r;
  assign ctrl_byte   = ctrl_byte_r;
  assign seq_error   = seq_error_r;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder: directed byte sequences, queued expected events.
// Define PS2_SCAN_TIMEOUT_EN to also exercise the prefix timeout.
module tb_ps2_scancode_decoder;
  localparam int DEPTH = 8;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] received_data = 8'h00;
  logic       received_data_en = 1'b0;
  logic       ev_valid;
  logic       ev_ready = 1'b0;
  logic [7:0] ev_code;
  logic       ev_extended;
  logic       ev_break;
  logic [3:0] fill_level;
  logic       overflow;
  logic       clr_overflow = 1'b0;
  logic       ctrl_valid;
  logic [7:0] ctrl_byte;
  logic       seq_error;

  int n_checks = 0;
  int n_fail = 0;
  logic [9:0] exp_q[$];
  logic [7:0] ctrl_q[$];
  int seq_pending = 0;

  ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(100)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .received_data(received_data), .received_data_en(received_data_en),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
    .ev_extended(ev_extended), .ev_break(ev_break), .fill_level(fill_level),
    .overflow(overflow), .clr_overflow(clr_overflow),
    .ctrl_valid(ctrl_valid), .ctrl_byte(ctrl_byte), .seq_error(seq_error)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every DUT output transaction against the scoreboard
  always @(negedge CLOCK_50) begin
    if (!reset) begin
      if (ev_valid && ev_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL ev_unexpected: got %0h expected none", {ev_break, ev_extended, ev_code});
        end else begin
          check("ev", {22'd0, ev_break, ev_extended, ev_code}, {22'd0, exp_q.pop_front()});
        end
      end
      if (ctrl_valid) begin
        if (ctrl_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL ctrl_unexpected: got %0h expected none", ctrl_byte);
        end else begin
          check("ctrl_byte", {24'd0, ctrl_byte}, {24'd0, ctrl_q.pop_front()});
        end
      end
      if (seq_error) begin
        check("seq_error_expected", 32'(seq_pending > 0), 32'd1);
        if (seq_pending > 0) seq_pending--;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    received_data = b;
    received_data_en = 1'b1;
    @(posedge CLOCK_50); #1;
    received_data_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK_50); #1;
    end
  endtask

  task automatic drain();
    ev_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (fill_level == 4'd0 && exp_q.size() == 0 && seq_pending == 0 && ctrl_q.size() == 0) break;
      @(posedge CLOCK_50); #1;
    end
    idle(2);
    check("drain_fill", {28'd0, fill_level}, 32'd0);
    check("drain_scoreboard", exp_q.size() + ctrl_q.size() + seq_pending, 32'd0);
  endtask

  task automatic pulse_clr();
    clr_overflow = 1'b1;
    @(posedge CLOCK_50); #1;
    clr_overflow = 1'b0;
  endtask

  initial begin
    idle(3);
    reset = 1'b0;
    idle(1);
    check("rst_ev_valid", {31'd0, ev_valid}, 32'd0);
    check("rst_fill", {28'd0, fill_level}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_ctrl", {23'd0, ctrl_valid, ctrl_byte}, 32'd0);
    check("rst_seq_error", {31'd0, seq_error}, 32'd0);
    check("rst_head", {22'd0, ev_break, ev_extended, ev_code}, 32'd0);

    // make and break of 1C, held in the FIFO
    exp_q.push_back(10'h01C); send(8'h1C);
    check("first_valid", {31'd0, ev_valid}, 32'd1);
    send(8'hF0);
    exp_q.push_back(10'h21C); send(8'h1C);
    check("fill_two", {28'd0, fill_level}, 32'd2);
    drain();

    // extended make/break, duplicated E0
    send(8'hE0); exp_q.push_back(10'h175); send(8'h75);
    send(8'hE0); send(8'hF0); exp_q.push_back(10'h375); send(8'h75);
    send(8'hE0); send(8'hE0); exp_q.push_back(10'h16B); send(8'h6B);
    exp_q.push_back(10'h0E1); send(8'hE1);
    drain();

    // control byte in IDLE, then as an ordinary code after F0
    ctrl_q.push_back(8'hFA); send(8'hFA);
    check("ctrl_no_push", {28'd0, fill_level}, 32'd0);
    send(8'hF0); exp_q.push_back(10'h2FA); send(8'hFA);
    drain();

    // fill to capacity, drop the ninth
    ev_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i <= DEPTH) exp_q.push_back({2'b00, 8'(i)});
      send(8'(i));
    end
    check("full_fill", {28'd0, fill_level}, 32'd8);
    check("full_overflow", {31'd0, overflow}, 32'd1);
    ev_ready = 1'b1;
    exp_q.push_back(10'h00A); send(8'h0A);
    check("full_pushpop_fill", {28'd0, fill_level}, 32'd8);
    drain();
    check("overflow_sticky", {31'd0, overflow}, 32'd1);
    pulse_clr();
    check("overflow_cleared", {31'd0, overflow}, 32'd0);

    // new drop together with clear: overflow must stay set
    ev_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back({2'b00, 8'h11 + 8'(i)});
      send(8'h11 + 8'(i));
    end
    clr_overflow = 1'b1; send(8'h19); clr_overflow = 1'b0;
    check("set_wins", {31'd0, overflow}, 32'd1);
    check("set_wins_fill", {28'd0, fill_level}, 32'd8);
    drain();
    pulse_clr();
    check("overflow_cleared2", {31'd0, overflow}, 32'd0);

    // illegal prefix, then recovery
    send(8'hF0); seq_pending++; send(8'hF0);
    exp_q.push_back(10'h01C); send(8'h1C);
    drain();

    // reset mid-sequence loses queued events and the prefix
    ev_ready = 1'b0;
    send(8'h55); send(8'hE0);
    reset = 1'b1; idle(1); reset = 1'b0;
    exp_q.delete();
    check("reset_fill", {28'd0, fill_level}, 32'd0);
    check("reset_ctrl_byte", {24'd0, ctrl_byte}, 32'd0);
    exp_q.push_back(10'h01C); send(8'h1C);
    drain();

`ifdef PS2_SCAN_TIMEOUT_EN
    send(8'hE0);
    seq_pending++;
    idle(105);
    check("timeout_fired", seq_pending, 32'd0);
    exp_q.push_back(10'h074); send(8'h74);
    drain();
`endif

    check("final_ev_q", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
